// File: rtl/onehot_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the round-robin arbiter (slave).
interface onehot_rr_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] req;
    logic            done;
    logic [NREQ-1:0] gnt;
    logic            gnt_valid;
    logic [IDW-1:0]  gnt_id;
    logic            preempt;

    modport master (
        output req, done,
        input  gnt, gnt_valid, gnt_id, preempt
    );

    modport slave (
        input  req, done,
        output gnt, gnt_valid, gnt_id, preempt
    );
endinterface

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with one-hot registered grant, a mandatory idle cycle between
// owners, and a hold limit that revokes the grant when another requester is waiting.
module onehot_rr_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    onehot_rr_arbiter_if.slave    bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] ID_LAST   = IDW'(NREQ - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] gnt_r, gnt_nxt;
    logic            valid_r, valid_nxt;
    logic [IDW-1:0]  id_r, id_nxt;
    logic [IDW-1:0]  ptr, ptr_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic            preempt_r, preempt_nxt;

    logic [IDW-1:0]  pick_id;
    logic            pick_found;
    logic            owner_req, others_req, at_limit, release_now;

    // Circular priority search starting at ptr; first hit wins.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        pick_id    = '0;
        pick_found = 1'b0;
        idx        = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!pick_found && bus.req[idx]) begin
                pick_found = 1'b1;
                pick_id    = IDW'(idx);
            end
        end
    end

    assign owner_req   = bus.req[id_r];
    assign others_req  = |(bus.req & ~gnt_r);
    assign at_limit    = (hold_cnt == HOLD_LAST);
    assign release_now = bus.done || !owner_req || (at_limit && others_req);

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt_r;
        valid_nxt   = valid_r;
        id_nxt      = id_r;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        preempt_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = OWN;
                    gnt_nxt   = NREQ'(1) << pick_id;
                    valid_nxt = 1'b1;
                    id_nxt    = pick_id;
                    hold_nxt  = '0;
                end
            end
            OWN: begin
                if (release_now) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = '0;
                    valid_nxt   = 1'b0;
                    ptr_nxt     = (id_r == ID_LAST) ? '0 : IDW'(id_r + 1'b1);
                    hold_nxt    = '0;
                    // Only the hold limit can release while done=0 and the owner still requests.
                    preempt_nxt = !bus.done && owner_req;
                end else if (!at_limit) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_r     <= '0;
            valid_r   <= 1'b0;
            id_r      <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
            preempt_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt_r     <= gnt_nxt;
            valid_r   <= valid_nxt;
            id_r      <= id_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            preempt_r <= preempt_nxt;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_valid = valid_r;
    assign bus.gnt_id    = id_r;
    assign bus.preempt   = preempt_r;
endmodule
